draw_scheduler: RTL and testbench

Frame-paced controller that shares the single VGA adapter write port (x, y, colour, writeEn) between NUM_REQ sprite requesters (dino, obstacles, ground marker). Once per frame tick it snapshots every requester's rectangle, erases the rectangle drawn last frame in the background colour, and fills the new one, one pixel per cycle. It sits between the game FSM/datapath and the VGA adapter inside the game top level, replacing ad-hoc plotting logic.

---
 rtl/draw_scheduler_pkg.sv | 25 ++
 rtl/rect_scanner.sv | 58 +++++
 rtl/draw_scheduler.sv | 192 +++++++++++++++++++
 tb/tb_draw_scheduler.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/draw_scheduler_pkg.sv
// Shared screen geometry, rectangle type and FSM encoding for the frame-paced
// sprite draw scheduler.
package draw_scheduler_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int COLOUR_W = 3;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int DIM_W    = 4;

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_ERASE, S_DRAW, S_NEXT, S_DONE
  } state_t;

  typedef struct packed {
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [DIM_W-1:0] w;
    logic [DIM_W-1:0] h;
  } rect_t;

  function automatic logic rect_visible(input logic en, input rect_t r);
    return en && (r.w != '0) && (r.h != '0);
  endfunction
endpackage

// File: rtl/rect_scanner.sv
// Raster walker over one rectangle. x/y/in_bounds describe the scan position
// that becomes current at the next clock edge, so the caller can register it.
module rect_scanner
  import draw_scheduler_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             step,
  input  logic [X_W-1:0]   x0,
  input  logic [Y_W-1:0]   y0,
  input  logic [DIM_W-1:0] w,
  input  logic [DIM_W-1:0] h,
  output logic [X_W-1:0]   x,
  output logic [Y_W-1:0]   y,
  output logic             in_bounds,
  output logic             last
);
  logic [DIM_W-1:0] dx, dy, dx_nxt, dy_nxt;
  logic [X_W:0]     x_sum;
  logic [Y_W:0]     y_sum;

  // w/h belong to the rectangle currently being scanned
  assign last = (dx == w - DIM_W'(1)) && (dy == h - DIM_W'(1));

  always_comb begin
    dx_nxt = dx;
    dy_nxt = dy;
    if (start) begin
      dx_nxt = '0;
      dy_nxt = '0;
    end else if (step) begin
      if (dx == w - DIM_W'(1)) begin
        dx_nxt = '0;
        dy_nxt = dy + DIM_W'(1);
      end else begin
        dx_nxt = dx + DIM_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dx <= '0;
      dy <= '0;
    end else begin
      dx <= dx_nxt;
      dy <= dy_nxt;
    end
  end

  // one extra bit so positions past the screen edge clip instead of wrapping
  assign x_sum     = {1'b0, x0} + {{(X_W+1-DIM_W){1'b0}}, dx_nxt};
  assign y_sum     = {1'b0, y0} + {{(Y_W+1-DIM_W){1'b0}}, dy_nxt};
  assign in_bounds = (x_sum < (X_W+1)'(SCREEN_W)) && (y_sum < (Y_W+1)'(SCREEN_H));
  assign x         = x_sum[X_W-1:0];
  assign y         = y_sum[Y_W-1:0];
endmodule

// File: rtl/draw_scheduler.sv
// Shares the VGA write port between NUM_REQ sprite requesters: once per frame
// tick, erase each requester's previous rectangle and fill its new one.
module draw_scheduler
  import draw_scheduler_pkg::*;
#(
  parameter int                  NUM_REQ      = 3,
  parameter int                  FRAME_CYCLES = 416666,
  parameter logic [COLOUR_W-1:0] BG_COLOUR    = 3'b000
)(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic [NUM_REQ-1:0]           req_en,
  input  logic [X_W*NUM_REQ-1:0]       req_x,
  input  logic [Y_W*NUM_REQ-1:0]       req_y,
  input  logic [DIM_W*NUM_REQ-1:0]     req_w,
  input  logic [DIM_W*NUM_REQ-1:0]     req_h,
  input  logic [COLOUR_W*NUM_REQ-1:0]  req_colour,
  output logic [X_W-1:0]               x,
  output logic [Y_W-1:0]               y,
  output logic [COLOUR_W-1:0]          colour,
  output logic                         writeEn,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         overrun
);
  localparam int CNT_W = (FRAME_CYCLES > 2) ? $clog2(FRAME_CYCLES) : 1;
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  state_t state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt, idx_inc;
  logic [CNT_W-1:0] cnt;
  logic             tick;

  rect_t [NUM_REQ-1:0]                live_rect, new_rect, old_rect;
  logic  [NUM_REQ-1:0][COLOUR_W-1:0]  live_col, new_col;
  logic  [NUM_REQ-1:0]                live_ok, new_ok, old_valid;

  rect_t               cur_rect, nxt_rect;
  logic [COLOUR_W-1:0] nxt_col;
  logic                scan_start, scan_step, scan_nxt;
  logic [X_W-1:0]      sx;
  logic [Y_W-1:0]      sy;
  logic                s_in, s_last;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    assign live_rect[g] = {req_x[g*X_W +: X_W], req_y[g*Y_W +: Y_W],
                           req_w[g*DIM_W +: DIM_W], req_h[g*DIM_W +: DIM_W]};
    assign live_col[g]  = req_colour[g*COLOUR_W +: COLOUR_W];
    assign live_ok[g]   = rect_visible(req_en[g], live_rect[g]);
  end

  assign tick    = (cnt == '0);
  assign idx_inc = idx + IDX_W'(1);

  // nxt_rect/nxt_col describe the rectangle scanned in the next cycle; in LATCH
  // the shadows are still loading, so requester 0 is taken from the live inputs.
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    scan_start = 1'b0;
    scan_step  = 1'b0;
    cur_rect   = (state == S_ERASE) ? old_rect[idx] : new_rect[idx];
    nxt_rect   = cur_rect;
    nxt_col    = new_col[idx];
    case (state)
      S_IDLE:  if (tick && enable) state_nxt = S_LATCH;
      S_LATCH: begin
        idx_nxt    = '0;
        scan_start = 1'b1;
        if (old_valid[0]) begin
          state_nxt = S_ERASE;
          nxt_rect  = old_rect[0];
        end else if (live_ok[0]) begin
          state_nxt = S_DRAW;
          nxt_rect  = live_rect[0];
          nxt_col   = live_col[0];
        end else begin
          state_nxt = S_NEXT;
        end
      end
      S_ERASE: begin
        if (!s_last) begin
          scan_step = 1'b1;
        end else if (new_ok[idx]) begin
          state_nxt  = S_DRAW;
          scan_start = 1'b1;
          nxt_rect   = new_rect[idx];
        end else begin
          state_nxt = S_NEXT;
        end
      end
      S_DRAW: begin
        if (!s_last) scan_step = 1'b1;
        else         state_nxt = S_NEXT;
      end
      S_NEXT: begin
        if (idx == LAST_IDX) begin
          state_nxt = S_DONE;
        end else begin
          idx_nxt    = idx_inc;
          scan_start = 1'b1;
          if (old_valid[idx_inc]) begin
            state_nxt = S_ERASE;
            nxt_rect  = old_rect[idx_inc];
          end else if (new_ok[idx_inc]) begin
            state_nxt = S_DRAW;
            nxt_rect  = new_rect[idx_inc];
            nxt_col   = new_col[idx_inc];
          end else begin
            state_nxt = S_NEXT;
          end
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign scan_nxt = (state_nxt == S_ERASE) || (state_nxt == S_DRAW);

  rect_scanner u_scan (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (scan_start),
    .step      (scan_step),
    .x0        (nxt_rect.x),
    .y0        (nxt_rect.y),
    .w         (cur_rect.w),
    .h         (cur_rect.h),
    .x         (sx),
    .y         (sy),
    .in_bounds (s_in),
    .last      (s_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      idx        <= '0;
      cnt        <= CNT_W'(FRAME_CYCLES - 1);
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      cnt        <= tick ? CNT_W'(FRAME_CYCLES - 1) : cnt - CNT_W'(1);
      busy       <= (state_nxt != S_IDLE);
      frame_done <= (state == S_DONE);
      if (tick && (state != S_IDLE)) overrun <= 1'b1;
    end
  end

  // pixel port: address/colour only move on a real write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x       <= '0;
      y       <= '0;
      colour  <= '0;
      writeEn <= 1'b0;
    end else begin
      writeEn <= scan_nxt && s_in;
      if (scan_nxt && s_in) begin
        x      <= sx;
        y      <= sy;
        colour <= (state_nxt == S_ERASE) ? BG_COLOUR : nxt_col;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      new_rect  <= '0;
      new_col   <= '0;
      new_ok    <= '0;
      old_rect  <= '0;
      old_valid <= '0;
    end else begin
      if (state == S_LATCH) begin
        new_rect <= live_rect;
        new_col  <= live_col;
        new_ok   <= live_ok;
      end
      if (state == S_NEXT) begin
        old_rect[idx]  <= new_rect[idx];
        old_valid[idx] <= new_ok[idx];
      end
    end
  end
endmodule

// File: tb/tb_draw_scheduler.sv
// Bench for draw_scheduler: per-frame expected write traces are built from
// the erase/draw/clip rules and compared cycle by cycle.
module tb_draw_scheduler;
  logic        clk = 1'b0;
  logic        rst_n, rst16_n, enable;
  logic [1:0]  req_en;
  logic [15:0] req_x;
  logic [13:0] req_y;
  logic [7:0]  req_w, req_h;
  logic [5:0]  req_colour;
  logic [7:0]  x, x16;
  logic [6:0]  y, y16;
  logic [2:0]  colour, colour16;
  logic        writeEn, busy, frame_done, overrun;
  logic        we16, busy16, fd16, ovr16;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_rise = 0;

  int s_en[2], s_x[2], s_y[2], s_w[2], s_h[2], s_c[2];
  int m_valid[2], m_x[2], m_y[2], m_w[2], m_h[2];
  logic [18:0] exp_q[$];

  draw_scheduler #(.NUM_REQ(2), .FRAME_CYCLES(64), .BG_COLOUR(3'b000)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .req_en(req_en), .req_x(req_x),
    .req_y(req_y), .req_w(req_w), .req_h(req_h), .req_colour(req_colour),
    .x(x), .y(y), .colour(colour), .writeEn(writeEn), .busy(busy),
    .frame_done(frame_done), .overrun(overrun));

  draw_scheduler #(.NUM_REQ(2), .FRAME_CYCLES(16), .BG_COLOUR(3'b000)) u_ovr (
    .clk(clk), .rst_n(rst16_n), .enable(enable), .req_en(req_en), .req_x(req_x),
    .req_y(req_y), .req_w(req_w), .req_h(req_h), .req_colour(req_colour),
    .x(x16), .y(y16), .colour(colour16), .writeEn(we16), .busy(busy16),
    .frame_done(fd16), .overrun(ovr16));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic set_req(input int i, input int en, input int px, input int py,
                         input int w, input int h, input int c);
    s_en[i] = en; s_x[i] = px; s_y[i] = py; s_w[i] = w; s_h[i] = h; s_c[i] = c;
  endtask

  task automatic apply();
    for (int i = 0; i < 2; i++) begin
      req_en[i]             = s_en[i][0];
      req_x[i*8 +: 8]       = 8'(s_x[i]);
      req_y[i*7 +: 7]       = 7'(s_y[i]);
      req_w[i*4 +: 4]       = 4'(s_w[i]);
      req_h[i*4 +: 4]       = 4'(s_h[i]);
      req_colour[i*3 +: 3]  = 3'(s_c[i]);
    end
  endtask

  task automatic scramble();
    req_en = 2'($urandom); req_x = 16'($urandom); req_y = 14'($urandom);
    req_w = 8'($urandom); req_h = 8'($urandom); req_colour = 6'($urandom);
    enable = 1'($urandom_range(0, 1));
  endtask

  task automatic add_rect(input int px, input int py, input int w, input int h, input int c);
    for (int dy = 0; dy < h; dy++)
      for (int dx = 0; dx < w; dx++)
        if (px + dx <= 159 && py + dy <= 119)
          exp_q.push_back({1'b1, 8'(px + dx), 7'(py + dy), 3'(c)});
        else
          exp_q.push_back(19'd0);
  endtask

  // one entry per busy cycle: LATCH, per requester erase/draw scans + NEXT, DONE
  task automatic build_trace();
    int ok;
    exp_q.delete();
    exp_q.push_back(19'd0);
    for (int i = 0; i < 2; i++) begin
      if (m_valid[i] != 0) add_rect(m_x[i], m_y[i], m_w[i], m_h[i], 0);
      ok = (s_en[i] != 0 && s_w[i] != 0 && s_h[i] != 0) ? 1 : 0;
      if (ok != 0) add_rect(s_x[i], s_y[i], s_w[i], s_h[i], s_c[i]);
      exp_q.push_back(19'd0);
      m_valid[i] = ok; m_x[i] = s_x[i]; m_y[i] = s_y[i]; m_w[i] = s_w[i]; m_h[i] = s_h[i];
    end
    exp_q.push_back(19'd0);
  endtask

  task automatic run_frame(input int exp_rise);
    int n;
    logic [18:0] e;
    build_trace();
    n = 0;
    while (busy !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    chk("busy_rise", busy, 1);
    if (busy !== 1'b1) return;
    chk("rise_cycle", cyc, exp_rise);
    last_rise = cyc;
    n = 0;
    while (busy === 1'b1 && n < 400) begin
      e = (n < exp_q.size()) ? exp_q[n] : 19'd0;
      chk("write_en", writeEn, e[18]);
      if (e[18] && writeEn === 1'b1) chk("pixel", {x, y, colour}, e[17:0]);
      if (n == 1) scramble();
      n++;
      @(negedge clk);
    end
    chk("frame_len", n, exp_q.size());
    chk("frame_done", frame_done, 1);
    @(negedge clk);
    chk("frame_done_pulse", frame_done, 0);
  endtask

  initial begin
    int base, bad, nxt, n;
    rst_n = 0; rst16_n = 0; enable = 0;
    req_en = '0; req_x = '0; req_y = '0; req_w = '0; req_h = '0; req_colour = '0;
    for (int i = 0; i < 2; i++) begin m_valid[i] = 0; set_req(i, 0, 0, 0, 0, 0, 0); end
    repeat (3) @(negedge clk);
    chk("rst_out", {x, y, colour, writeEn, busy, frame_done, overrun}, 0);
    chk("rst16_out", {we16, busy16, fd16, ovr16}, 0);

    // directed: draw, move, erase-only, empty, clipped
    set_req(0, 1, 10, 20, 2, 2, 4); apply(); enable = 1;
    rst_n = 1; base = cyc;
    run_frame(base + 64);
    set_req(0, 1, 11, 20, 2, 2, 4); apply(); enable = 1;
    run_frame(last_rise + 64);
    set_req(0, 0, 11, 20, 2, 2, 4); apply(); enable = 1;
    run_frame(last_rise + 64);
    apply(); enable = 1;
    run_frame(last_rise + 64);
    set_req(0, 1, 158, 119, 4, 2, 4); apply(); enable = 1;
    run_frame(last_rise + 64);
    chk("no_overrun", overrun, 0);

    // randomized frames, some with the tick suppressed by enable=0
    for (int f = 0; f < 24; f++) begin
      for (int i = 0; i < 2; i++)
        set_req(i, $urandom_range(0, 3) != 0, $urandom_range(0, 255), $urandom_range(0, 127),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 7));
      apply();
      if ($urandom_range(0, 4) == 0) begin
        enable = 0; bad = 0;
        while (cyc < last_rise + 72) begin
          @(negedge clk);
          if (busy !== 1'b0 || writeEn !== 1'b0) bad = 1;
        end
        chk("skip_idle", bad, 0);
        nxt = last_rise + 128;
      end else begin
        nxt = last_rise + 64;
      end
      enable = 1;
      run_frame(nxt);
    end
    chk("no_overrun_rand", overrun, 0);

    // reset in the middle of a draw scan
    set_req(0, 1, 30, 40, 3, 3, 5); set_req(1, 0, 0, 0, 0, 0, 0); apply(); enable = 1;
    n = 0;
    while (writeEn !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk("pre_reset_write", writeEn, 1);
    #2 rst_n = 0;
    #1;
    chk("abort_we", writeEn, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ovr", overrun, 0);
    for (int i = 0; i < 2; i++) m_valid[i] = 0;
    @(negedge clk);
    enable = 0; rst_n = 1; base = cyc; bad = 0;
    repeat (70) begin
      @(negedge clk);
      if (busy !== 1'b0 || writeEn !== 1'b0) bad = 1;
    end
    chk("post_reset_quiet", bad, 0);
    enable = 1;
    run_frame(base + 128);

    // frame longer than the tick period on the 16-cycle instance
    set_req(0, 1, 0, 0, 8, 8, 1); set_req(1, 0, 0, 0, 0, 0, 0); apply(); enable = 1;
    rst16_n = 1;
    repeat (20) @(negedge clk);
    chk("ovr_busy", busy16, 1);
    chk("ovr_before", ovr16, 0);
    repeat (20) @(negedge clk);
    chk("ovr_set", ovr16, 1);
    repeat (150) @(negedge clk);
    chk("ovr_sticky", ovr16, 1);
    enable = 0;
    repeat (50) @(negedge clk);
    chk("ovr_sticky_dis", ovr16, 1);
    rst16_n = 0;
    #1;
    chk("ovr_reset", ovr16, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
